// File: rtl/mf_clken_pkg.sv
// Shared types and width helpers for the multi-channel clock-enable generator.
package mf_clken_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StRun    = 2'd2
    } clken_state_e;

    // Channel-select width; a single channel still needs a 1-bit port.
    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Lock counter must be able to hold LOCK_CYCLES itself.
    function automatic int unsigned cnt_width(input int unsigned lock_cycles);
        return (lock_cycles > 0) ? $clog2(lock_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/mf_clken_nco.sv
// One clock-enable channel: phase accumulator, glitch-free increment update and
// divided square wave.
module mf_clken_nco #(
    parameter int unsigned ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enter_run,
    input  logic             run,
    input  logic             leave_run,
    input  logic             wr,
    input  logic [ACC_W-1:0] cfg_inc,
    input  logic [ACC_W-1:0] cfg_phase,
    output logic             ce,
    output logic             tog,
    output logic             pend
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] phase_q;
    logic [ACC_W-1:0] pend_inc_q;
    logic             pend_q;
    logic             ce_q;
    logic             tog_q;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             wr_direct;

    assign sum   = {1'b0, acc_q} + {1'b0, inc_q};
    assign carry = run & sum[ACC_W];
    // While running, a live increment may only change on a wrap, so it is parked.
    assign wr_direct = wr && (!run || (inc_q == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            inc_q      <= '0;
            phase_q    <= '0;
            pend_inc_q <= '0;
            pend_q     <= 1'b0;
            ce_q       <= 1'b0;
            tog_q      <= 1'b0;
        end else begin
            if (enter_run) begin
                acc_q <= phase_q;
            end else if (run) begin
                acc_q <= sum[ACC_W-1:0];
            end

            ce_q <= carry;

            if (!run) begin
                tog_q <= 1'b0;
            end else if (carry) begin
                tog_q <= ~tog_q;
            end

            if (wr_direct) begin
                inc_q   <= cfg_inc;
                phase_q <= cfg_phase;
            end else if (wr) begin
                phase_q    <= cfg_phase;
                pend_inc_q <= cfg_inc;
                pend_q     <= 1'b1;
            end else if (pend_q && (leave_run || carry)) begin
                inc_q  <= pend_inc_q;
                pend_q <= 1'b0;
            end
        end
    end

    assign ce   = ce_q;
    assign tog  = tog_q;
    assign pend = pend_q;

    // The top-level handshake holds cfg_ready low while anything is parked.
    a_no_wr_while_pending: assert property (@(posedge clk) disable iff (rst)
        !(wr && pend_q));

endmodule

// File: rtl/mf_clken_gen.sv
// Multi-channel NCO clock-enable generator gated by a PLL lock settle FSM.
module mf_clken_gen
    import mf_clken_pkg::*;
#(
    parameter  int unsigned NUM_CH      = 5,
    parameter  int unsigned ACC_W       = 32,
    parameter  int unsigned LOCK_CYCLES = 255,
    localparam int unsigned CH_W        = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] tog,
    output logic              running
);

    localparam int unsigned CNT_W = cnt_width(LOCK_CYCLES);

    clken_state_e      state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              running_q;
    logic              lock_done;
    logic              enter_run;
    logic              run;
    logic              leave_run;
    logic [NUM_CH-1:0] pend;

    assign lock_done = (cnt_q == CNT_W'(LOCK_CYCLES));
    assign enter_run = (state_q == StSettle) && pll_locked && lock_done;
    assign run       = (state_q == StRun) && pll_locked;
    assign leave_run = (state_q == StRun) && !pll_locked;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pll_locked) begin
                        state_q <= StSettle;
                        cnt_q   <= '0;
                    end
                end
                StSettle: begin
                    if (!pll_locked) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (lock_done) begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StRun: begin
                    if (!pll_locked) begin
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    cnt_q     <= '0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign running = running_q;

    // Requests for channels beyond NUM_CH match no instance and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;
        assign wr = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

        mf_clken_nco #(
            .ACC_W(ACC_W)
        ) u_nco (
            .clk       (clk),
            .rst       (rst),
            .enter_run (enter_run),
            .run       (run),
            .leave_run (leave_run),
            .wr        (wr),
            .cfg_inc   (cfg_inc),
            .cfg_phase (cfg_phase),
            .ce        (ce[i]),
            .tog       (tog[i]),
            .pend      (pend[i])
        );
    end

    assign cfg_ready = ~|pend;

    a_quiet_when_stopped: assert property (@(posedge clk) disable iff (rst)
        !running |-> (ce == '0) && (tog == '0));

endmodule

// File: tb/tb_mf_clken_gen.sv
// Randomised and directed bench for mf_clken_gen against a lock-streak / modular-sum model.
module tb_mf_clken_gen;

    localparam int unsigned NUM_CH      = 2;
    localparam int unsigned ACC_W       = 8;
    localparam int unsigned LOCK_CYCLES = 4;
    localparam int          RUN_AT      = LOCK_CYCLES + 2;
    localparam int          MOD         = 1 << ACC_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              pll_locked;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [0:0]        cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [ACC_W-1:0]  cfg_phase;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] tog;
    logic              running;

    int checks   = 0;
    int failures = 0;

    // Model: running means the last LOCK_CYCLES+2 samples of pll_locked were all high.
    int                m_streak;
    int                m_acc  [NUM_CH];
    int                m_inc  [NUM_CH];
    int                m_ph   [NUM_CH];
    int                m_pend [NUM_CH];
    bit                m_pv   [NUM_CH];
    logic [NUM_CH-1:0] m_ce;
    logic [NUM_CH-1:0] m_tog;

    mf_clken_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .cfg_phase  (cfg_phase),
        .ce         (ce),
        .tog        (tog),
        .running    (running)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
        bit r = 1'b1;
        for (int c = 0; c < NUM_CH; c++) if (m_pv[c]) r = 1'b0;
        return r;
    endfunction

    function automatic logic [5:0] m_vec();
        return {(m_streak >= RUN_AT), m_ready(), m_tog, m_ce};
    endfunction

    task automatic model_update();
        bit prev_run, staying, leaving, entering, accept, carry;
        int s;
        if (rst) begin
            m_streak = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_acc[c] = 0; m_inc[c] = 0; m_ph[c] = 0; m_pend[c] = 0; m_pv[c] = 0;
            end
            m_ce  = '0;
            m_tog = '0;
            return;
        end
        prev_run = (m_streak >= RUN_AT);
        accept   = cfg_valid && m_ready();
        if (!pll_locked) m_streak = 0;
        else if (m_streak <= RUN_AT) m_streak++;
        entering = (m_streak == RUN_AT);
        staying  = prev_run && pll_locked;
        leaving  = prev_run && !pll_locked;
        for (int c = 0; c < NUM_CH; c++) begin
            carry = 1'b0;
            if (entering) begin
                m_acc[c] = m_ph[c];
            end else if (staying) begin
                s        = m_acc[c] + m_inc[c];
                carry    = (s >= MOD);
                m_acc[c] = s % MOD;
            end
            m_ce[c] = carry;
            if (m_streak < RUN_AT) m_tog[c] = 1'b0;
            else if (carry) m_tog[c] = ~m_tog[c];
            if (accept && int'(cfg_ch) == c) begin
                m_ph[c] = int'(cfg_phase);
                if (staying && m_inc[c] != 0) begin
                    m_pend[c] = int'(cfg_inc);
                    m_pv[c]   = 1'b1;
                end else begin
                    m_inc[c] = int'(cfg_inc);
                end
            end else if (m_pv[c] && (leaving || carry)) begin
                m_inc[c] = m_pend[c];
                m_pv[c]  = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic send(input int ch, input int inc, input int ph);
        cfg_valid = 1'b1;
        cfg_ch    = 1'(ch);
        cfg_inc   = ACC_W'(inc);
        cfg_phase = ACC_W'(ph);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_running(output int n);
        n = 0;
        while (!running && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; pll_locked = 1'b0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_inc = '0; cfg_phase = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_locked = 1'b1; cfg_valid = 1'b1;
        cfg_ch = '0; cfg_inc = 8'd50; cfg_phase = 8'd7;
        step();
        step();
        checks++;
        if ({running, cfg_ready, tog, ce} !== 6'b010000) begin
            failures++;
            $display("FAIL reset_state: got %b expected %b", {running, cfg_ready, tog, ce}, 6'b010000);
        end
        rst = 1'b0; pll_locked = 1'b0; cfg_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({running, cfg_ready, tog, ce} !== m_vec()) begin
                failures++;
                $display("FAIL reset_idle cyc %0d: got %b expected %b", k,
                         {running, cfg_ready, tog, ce}, m_vec());
            end
        end
    endtask

    task automatic test_lock_to_run();
        do_reset();
        pll_locked = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (running !== (k >= 5) || ce !== '0) begin
                failures++;
                $display("FAIL lock_latency cyc %0d: got running=%b ce=%b expected running=%b ce=00",
                         k, running, ce, (k >= 5));
            end
        end
    endtask

    task automatic test_rate();
        int n, cnt;
        bit seen;
        logic [1:0] exp_ce, exp_tog;
        do_reset();
        send(0, 64, 0);
        send(1, 64, 128);
        pll_locked = 1'b1;
        wait_running(n);
        checks++;
        if (n != RUN_AT) begin
            failures++;
            $display("FAIL rate_lock_wait: got %0d cycles expected %0d", n, RUN_AT);
        end
        for (int r = 0; r <= 16; r++) begin
            if (r > 0) step();
            exp_ce[1]  = (r % 4 == 2);
            exp_ce[0]  = (r > 0) && (r % 4 == 0);
            exp_tog[1] = (((r + 2) / 4) % 2) == 1;
            exp_tog[0] = ((r / 4) % 2) == 1;
            checks++;
            if (ce !== exp_ce || tog !== exp_tog || {running, cfg_ready, tog, ce} !== m_vec()) begin
                failures++;
                $display("FAIL rate_64 r=%0d: got ce=%b tog=%b expected ce=%b tog=%b (model %b)",
                         r, ce, tog, exp_ce, exp_tog, m_vec());
            end
        end
        send(0, 96, 0);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step();
            seen = ce[0];
            checks++;
            if (cfg_ready !== seen) begin
                failures++;
                $display("FAIL rate_pending_ready k=%0d: got %b expected %b", k, cfg_ready, seen);
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rate_apply_timeout: got no ce0 expected one within 8 cycles");
        end
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (ce[0]) cnt++;
        end
        checks++;
        if (cnt != 3) begin
            failures++;
            $display("FAIL rate_96: got %0d pulses expected 3", cnt);
        end
    endtask

    task automatic test_glitch_free();
        int n;
        bit seen;
        do_reset();
        send(0, 64, 0);
        pll_locked = 1'b1;
        wait_running(n);
        for (int k = 0; k < 5; k++) step();
        send(0, 128, 0);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step();
            seen = ce[0];
            checks++;
            if (cfg_ready !== seen || {running, cfg_ready, tog, ce} !== m_vec()) begin
                failures++;
                $display("FAIL glitch_ready k=%0d: got ready=%b expected %b", k, cfg_ready, seen);
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL glitch_apply_timeout: got no ce0 expected one within 8 cycles");
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (ce[0] !== (k % 2 == 0) || {running, cfg_ready, tog, ce} !== m_vec()) begin
                failures++;
                $display("FAIL glitch_rate_128 k=%0d: got ce0=%b expected %b", k, ce[0], (k % 2 == 0));
            end
        end
    endtask

    task automatic test_lock_loss();
        int n;
        logic [1:0] exp_ce;
        do_reset();
        send(0, 64, 0);
        send(1, 64, 128);
        pll_locked = 1'b1;
        wait_running(n);
        step();
        step();
        send(0, 128, 0);
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL loss_pending: got ready=%b expected 0", cfg_ready);
        end
        pll_locked = 1'b0;
        step();
        checks++;
        if ({running, cfg_ready, tog, ce} !== 6'b010000 || m_vec() !== 6'b010000) begin
            failures++;
            $display("FAIL loss_outputs: got %b expected %b", {running, cfg_ready, tog, ce}, 6'b010000);
        end
        pll_locked = 1'b1;
        wait_running(n);
        checks++;
        if (n != RUN_AT) begin
            failures++;
            $display("FAIL loss_relock_wait: got %0d cycles expected %0d", n, RUN_AT);
        end
        for (int r = 0; r <= 8; r++) begin
            if (r > 0) step();
            exp_ce[1] = (r % 4 == 2);
            exp_ce[0] = (r > 0) && (r % 2 == 0);
            checks++;
            if (ce !== exp_ce || {running, cfg_ready, tog, ce} !== m_vec()) begin
                failures++;
                $display("FAIL loss_realign r=%0d: got ce=%b expected %b (model %b)",
                         r, ce, exp_ce, m_vec());
            end
        end
    endtask

    task automatic test_reset_in_run();
        int n;
        int pulses;
        do_reset();
        send(0, 64, 0);
        pll_locked = 1'b1;
        wait_running(n);
        step();
        step();
        send(0, 200, 0);
        rst = 1'b1;
        step();
        checks++;
        if ({running, cfg_ready, tog, ce} !== 6'b010000) begin
            failures++;
            $display("FAIL run_reset: got %b expected %b", {running, cfg_ready, tog, ce}, 6'b010000);
        end
        rst = 1'b0;
        wait_running(n);
        checks++;
        if (n != RUN_AT) begin
            failures++;
            $display("FAIL run_reset_relock: got %0d cycles expected %0d", n, RUN_AT);
        end
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (ce !== '0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL run_reset_inc_zero: got %0d ce cycles expected 0", pulses);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            rst        = ($urandom_range(0, 299) == 0);
            pll_locked = ($urandom_range(0, 59) != 0);
            cfg_valid  = ($urandom_range(0, 4) == 0);
            cfg_ch     = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       cfg_inc = '0;
                1:       cfg_inc = 8'd64;
                2:       cfg_inc = 8'd128;
                default: cfg_inc = ACC_W'($urandom);
            endcase
            cfg_phase = ACC_W'($urandom);
            step();
            checks++;
            if ({running, cfg_ready, tog, ce} !== m_vec()) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random cyc %0d: got %b expected %b", k,
                             {running, cfg_ready, tog, ce}, m_vec());
            end
        end
        rst = 1'b0;
        cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_to_run();
        test_rate();
        test_glitch_free();
        test_lock_loss();
        test_reset_in_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
